// File: rtl/dit_ifft8_seq_if.sv
// Valid/ready bin-in / sample-out bundle for the sequential 8-point inverse FFT.
interface dit_ifft8_seq_if #(
    parameter int unsigned DW = 12
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xr;
    logic signed [DW-1:0] xi;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] yr;
    logic signed [DW-1:0] yi;
    logic [2:0]           out_idx;
    logic                 busy;

    modport master (
        output in_valid, xr, xi, out_ready,
        input  in_ready, out_valid, yr, yi, out_idx, busy
    );

    modport slave (
        input  in_valid, xr, xi, out_ready,
        output in_ready, out_valid, yr, yi, out_idx, busy
    );
endinterface

// File: rtl/dit_ifft8_seq.sv
// 8-point radix-2 DIT inverse FFT: bins loaded bit-reversed, one shared butterfly
// run 3 stages x 4 butterflies in place with 1/2 scaling per stage, samples streamed out.
module dit_ifft8_seq #(
    parameter int unsigned DW   = 12,
    parameter int unsigned FRAC = 7
) (
    input logic            clk,
    input logic            rst_n,
    dit_ifft8_seq_if.slave io
);

    localparam int unsigned TW  = FRAC + 2;
    localparam int unsigned PW  = DW + TW + 1;
    localparam int unsigned AW  = DW + 2;
    localparam int          ONE = 1 << FRAC;
    localparam int          C45 = (181 * ONE + 128) / 256;
    localparam int          RND = 1 << (FRAC - 1);

    localparam logic signed [AW-1:0] VMAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] VMIN = AW'(-(1 << (DW - 1)));

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    localparam logic [3:0] LAST_BFLY = 4'd11;

    logic signed [DW-1:0] mem_r [8];
    logic signed [DW-1:0] mem_i [8];

    logic [1:0]           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [2:0]           idx_q, idx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic signed [DW-1:0] yr_q, yr_d;
    logic signed [DW-1:0] yi_q, yi_d;

    logic                 ld_we, bf_we;
    logic [2:0]           wa;
    logic [2:0]           idx_nx;

    logic [1:0]           stg, bfl, tk;
    logic [2:0]           pa, pb;
    logic signed [TW-1:0] w_r, w_i;
    logic signed [DW-1:0] a_r, a_i, b_r, b_i;
    logic signed [PW-1:0] p_r, p_i;
    logic signed [AW-1:0] t_r, t_i;
    logic signed [DW-1:0] na_r, na_i, nb_r, nb_i;

    // Halve with floor, then clamp into the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat_half(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] hv;
        hv = v >>> 1;
        if (hv > VMAX)      return DW'(VMAX);
        else if (hv < VMIN) return DW'(VMIN);
        else                return DW'(hv);
    endfunction

    assign wa     = {cnt_q[0], cnt_q[1], cnt_q[2]};
    assign idx_nx = idx_q + 3'd1;
    assign stg    = bcnt_q[3:2];
    assign bfl    = bcnt_q[1:0];

    // Butterfly pair addresses and twiddle index for stage stg, butterfly bfl.
    always_comb begin
        pa = 3'd0;
        pb = 3'd0;
        tk = 2'd0;
        case (stg)
            2'd0: begin
                pa = {bfl, 1'b0};
                pb = {bfl, 1'b1};
                tk = 2'd0;
            end
            2'd1: begin
                pa = {bfl[1], 1'b0, bfl[0]};
                pb = {bfl[1], 1'b1, bfl[0]};
                tk = {bfl[0], 1'b0};
            end
            default: begin
                pa = {1'b0, bfl};
                pb = {1'b1, bfl};
                tk = bfl;
            end
        endcase
    end

    // Inverse twiddles exp(+j*2*pi*k/8).
    always_comb begin
        w_r = '0;
        w_i = '0;
        case (tk)
            2'd0: begin w_r = TW'(ONE);  w_i = '0;        end
            2'd1: begin w_r = TW'(C45);  w_i = TW'(C45);  end
            2'd2: begin w_r = '0;        w_i = TW'(ONE);  end
            default: begin w_r = TW'(-C45); w_i = TW'(C45); end
        endcase
    end

    always_comb begin
        a_r  = mem_r[pa];
        a_i  = mem_i[pa];
        b_r  = mem_r[pb];
        b_i  = mem_i[pb];
        p_r  = PW'(b_r) * PW'(w_r) - PW'(b_i) * PW'(w_i) + PW'(RND);
        p_i  = PW'(b_r) * PW'(w_i) + PW'(b_i) * PW'(w_r) + PW'(RND);
        t_r  = AW'(p_r >>> FRAC);
        t_i  = AW'(p_i >>> FRAC);
        na_r = sat_half(AW'(a_r) + t_r);
        na_i = sat_half(AW'(a_i) + t_i);
        nb_r = sat_half(AW'(a_r) - t_r);
        nb_i = sat_half(AW'(a_i) - t_i);
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcnt_d      = bcnt_q;
        idx_d       = idx_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        yr_d        = yr_q;
        yi_d        = yi_q;
        ld_we       = 1'b0;
        bf_we       = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready_d = 1'b1;
                if (io.in_valid && in_ready_q) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d    = S_COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                        bcnt_d     = 4'd0;
                    end
                end
            end
            S_COMPUTE: begin
                bf_we  = 1'b1;
                busy_d = 1'b1;
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_q == LAST_BFLY) begin
                    // The final butterfly writes slots 3 and 7, so slot 0 is settled here.
                    state_d     = S_OUTPUT;
                    busy_d      = 1'b0;
                    bcnt_d      = 4'd0;
                    out_valid_d = 1'b1;
                    idx_d       = 3'd0;
                    yr_d        = mem_r[0];
                    yi_d        = mem_i[0];
                end
            end
            S_OUTPUT: begin
                out_valid_d = 1'b1;
                if (out_valid_q && io.out_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        idx_d       = 3'd0;
                    end else begin
                        idx_d = idx_nx;
                        yr_d  = mem_r[idx_nx];
                        yi_d  = mem_i[idx_nx];
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            cnt_q       <= 3'd0;
            bcnt_q      <= 4'd0;
            idx_q       <= 3'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            yr_q        <= '0;
            yi_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            yr_q        <= yr_d;
            yi_q        <= yi_d;
        end
    end

    // Working store: bit-reversed load, in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_r[wa] <= io.xr;
            mem_i[wa] <= io.xi;
        end
        if (bf_we) begin
            mem_r[pa] <= na_r;
            mem_i[pa] <= na_i;
            mem_r[pb] <= nb_r;
            mem_i[pb] <= nb_i;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.yr        = yr_q;
    assign io.yi        = yi_q;
    assign io.out_idx   = idx_q;
    assign io.busy      = busy_q;

endmodule

// File: tb/tb_dit_ifft8_seq.sv
// Bench for dit_ifft8_seq: arithmetic IFFT model plus literal frame expectations.
module tb_dit_ifft8_seq;

    localparam int unsigned DW = 12;

    logic clk;
    logic rst_n;

    dit_ifft8_seq_if #(.DW(DW)) io ();

    dit_ifft8_seq #(.DW(DW), .FRAC(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    int fr_r [8];
    int fr_i [8];
    int exp_r [8];
    int exp_i [8];
    int cap_r [8];
    int cap_i [8];
    int exp_idx = 8;
    bit armed = 1'b0;

    int twr [4] = '{128, 91, 0, -91};
    int twi [4] = '{0, 91, 128, 91};

    task automatic chk(input string name, input int act, input int req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int req, input int tol);
        nchk++;
        if (act > req + tol || act < req - tol) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d +-%0d", name, act, req, tol);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Textbook in-place radix-2 DIT over bit-reversed input, each stage halved.
    function automatic void ifft_model();
        int ar [8];
        int ai [8];
        for (int k = 0; k < 8; k++) begin
            int r;
            r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            ar[r] = fr_r[k];
            ai[r] = fr_i[k];
        end
        for (int s = 0; s < 3; s++) begin
            int h;
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    int k, tr, ti, xa_r, xa_i, xb_r, xb_i;
                    k    = j * (4 >> s);
                    xa_r = ar[g + j];
                    xa_i = ai[g + j];
                    xb_r = ar[g + j + h];
                    xb_i = ai[g + j + h];
                    tr = (xb_r * twr[k] - xb_i * twi[k] + 64) >>> 7;
                    ti = (xb_r * twi[k] + xb_i * twr[k] + 64) >>> 7;
                    ar[g + j]     = clamp((xa_r + tr) >>> 1);
                    ai[g + j]     = clamp((xa_i + ti) >>> 1);
                    ar[g + j + h] = clamp((xa_r - tr) >>> 1);
                    ai[g + j + h] = clamp((xa_i - ti) >>> 1);
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            exp_r[n] = ar[n];
            exp_i[n] = ai[n];
        end
    endfunction

    // Output checker: every presented sample is compared, stalls included.
    always @(negedge clk) begin
        if (rst_n && io.out_valid) begin
            if (!armed || exp_idx > 7) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_out_valid: got out_valid=1 idx=%0d, expected 0", io.out_idx);
            end else begin
                chk("out_idx", int'(io.out_idx), exp_idx);
                chk("yr", int'(io.yr), exp_r[exp_idx]);
                chk("yi", int'(io.yi), exp_i[exp_idx]);
                cap_r[exp_idx] = int'(io.yr);
                cap_i[exp_idx] = int'(io.yi);
                if (io.out_ready) begin
                    exp_idx++;
                    if (exp_idx == 8) armed = 1'b0;
                end
            end
        end
    end

    task automatic send_frame();
        int guard;
        ifft_model();
        for (int n = 0; n < 8; n++) begin
            cap_r[n] = -99999;
            cap_i[n] = -99999;
        end
        exp_idx = 0;
        armed   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            io.xr       = 12'(fr_r[i]);
            io.xi       = 12'(fr_i[i]);
            io.in_valid = 1'b1;
            @(negedge clk);
            guard = 0;
            while (!io.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                nchk++;
                nerr++;
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", guard);
            end
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
    endtask

    task automatic wait_outputs();
        int guard;
        guard = 0;
        while (exp_idx < 8 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (exp_idx < 8) begin
            nchk++;
            nerr++;
            $display("FAIL output_timeout: got %0d samples, expected 8", exp_idx);
        end
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"},  int'(io.in_ready), 0);
        chk({tag, "_out_valid"}, int'(io.out_valid), 0);
        chk({tag, "_yr"},        int'(io.yr), 0);
        chk({tag, "_yi"},        int'(io.yi), 0);
        chk({tag, "_out_idx"},   int'(io.out_idx), 0);
        chk({tag, "_busy"},      int'(io.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwait, nbusy, guard;
        int tone_r [8];
        int tone_i [8];
        tone_r = '{100, 71, 0, -71, -100, -71, 0, 71};
        tone_i = '{0, 71, 100, 71, 0, -71, -100, -71};

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.xr        = '0;
        io.xi        = '0;
        io.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Impulse in bin 0, with latency measurement.
        fr_r = '{800, 0, 0, 0, 0, 0, 0, 0};
        fr_i = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame();
        nwait = 0;
        nbusy = 0;
        @(negedge clk);
        while (!io.out_valid && nwait < 40) begin
            if (io.busy) nbusy++;
            nwait++;
            @(negedge clk);
        end
        chk("latency_cycles", nwait, 12);
        chk("busy_cycles", nbusy, 12);
        wait_outputs();
        for (int n = 0; n < 8; n++) begin
            chk("impulse_yr", cap_r[n], 100);
            chk("impulse_yi", cap_i[n], 0);
        end

        // DC spectrum; in_valid held high with junk while busy must be ignored.
        fr_r = '{80, 80, 80, 80, 80, 80, 80, 80};
        fr_i = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame();
        io.in_valid = 1'b1;
        io.xr       = 12'(555);
        io.xi       = 12'(-555);
        guard = 0;
        @(negedge clk);
        while (!io.out_valid && guard < 40) begin
            chk("in_ready_compute", int'(io.in_ready), 0);
            guard++;
            @(negedge clk);
        end
        chk("in_ready_output", int'(io.in_ready), 0);
        io.in_valid = 1'b0;
        wait_outputs();
        chk("dc_y0r", cap_r[0], 80);
        chk("dc_y0i", cap_i[0], 0);
        for (int n = 1; n < 8; n++) begin
            chk("dc_yr", cap_r[n], 0);
            chk("dc_yi", cap_i[n], 0);
        end

        // Tone in bin 1 with a five-cycle stall at sample 3.
        fr_r = '{0, 800, 0, 0, 0, 0, 0, 0};
        fr_i = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame();
        guard = 0;
        while (!(io.out_valid && io.out_idx == 3'd3) && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("stall_reached_idx3", int'(io.out_idx), 3);
        io.out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_idx", int'(io.out_idx), 3);
            chk("stall_valid", int'(io.out_valid), 1);
            chk("stall_yr", int'(io.yr), tone_r[3]);
        end
        io.out_ready = 1'b1;
        wait_outputs();
        for (int n = 0; n < 8; n++) begin
            chk_near("tone_yr", cap_r[n], tone_r[n], 1);
            chk_near("tone_yi", cap_i[n], tone_i[n], 1);
        end

        // Reset in the middle of COMPUTE aborts the frame.
        fr_r = '{800, 0, 0, 0, 0, 0, 0, 0};
        fr_i = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame();
        repeat (6) @(posedge clk);
        #1;
        chk("busy_before_reset", int'(io.busy), 1);
        rst_n = 1'b0;
        armed = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_frame();
        wait_outputs();
        for (int n = 0; n < 8; n++) begin
            chk("post_reset_yr", cap_r[n], 100);
            chk("post_reset_yi", cap_i[n], 0);
        end

        // Full-scale bins must not wrap.
        fr_r = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
        fr_i = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
        send_frame();
        wait_outputs();
        chk("sat_y0r", cap_r[0], 2047);
        chk("sat_y0i", cap_i[0], 2047);

        // Assorted large mixed-sign bins against the model only.
        fr_r = '{300, -1200, 2047, -2048, 5, 0, -777, 1500};
        fr_i = '{-2048, 900, -3, 2047, -1000, 640, 0, -15};
        send_frame();
        wait_outputs();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
